// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-side memory controller: state encodings,
// bus transfer sizes, the kseg0/kseg1 physical mask and the two small
// helpers that turn MEM-stage byte enables and virtual addresses into
// bus-side size and physical address.
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } dmem_state_e;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // Only aligned patterns reach us: full word, either half, or one byte.
  function automatic logic [1:0] sel2size(input logic [3:0] sel);
    case (sel)
      4'b1111:         sel2size = SIZE_WORD;
      4'b0011, 4'b1100: sel2size = SIZE_HALF;
      default:         sel2size = SIZE_BYTE;
    endcase
  endfunction

  // kseg0/kseg1 are unmapped windows onto the low 512 MB.
  function automatic logic [31:0] map_addr(input logic [31:0] a, input logic en);
    if (en && a[31:30] == 2'b10) map_addr = a & KSEG_MASK;
    else                         map_addr = a;
  endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences one MEM-stage load/store at a time onto the sram-like
// data bus (req/addr_ok/data_ok) and stalls the pipeline until it completes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_en_i/wr_i/sel_i      MEM-stage access request, direction, byte enables
//   mem_addr_i/wdata_i       virtual address, lane-replicated store data
//   flush_i                  exception flush; aborts or drains the access
//   stall_o                  hold IF..MEM while an access is in flight
//   rdata_o/rdata_valid_o    last load word; valid in the completion cycle
//   data_*                   sram-like bus towards the AXI bridge
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  dmem_state_e state, state_n;
  logic        start;
  logic        rsp_load;

  // sel==0 marks an address exception: nothing goes to the bus.
  assign start         = (state == S_IDLE) && mem_en_i && (mem_sel_i != 4'b0000) && !flush_i;
  assign stall_o       = start || (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);
  assign rdata_valid_o = (state == S_DONE);

  // A load response that belongs to a live instruction; drained ones are dropped.
  assign rsp_load = data_data_ok && !data_wr &&
                    (((state == S_REQ) && data_addr_ok) || (state == S_WAIT));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_REQ;
      S_REQ: begin
        if (flush_i) begin
          // Accepted but unanswered requests must still be drained.
          if (data_addr_ok && !data_data_ok) state_n = S_DRAIN;
          else                               state_n = S_IDLE;
        end else if (data_addr_ok) begin
          state_n = data_data_ok ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i)           state_n = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok) state_n = S_DONE;
      end
      // The instruction still sits in MEM here, so mem_en_i must not restart it.
      S_DONE:  state_n = S_IDLE;
      S_DRAIN: if (data_data_ok) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= SIZE_BYTE;
      data_addr  <= '0;
      data_wdata <= '0;
      rdata_o    <= '0;
    end else begin
      state    <= state_n;
      // The request is up for exactly the cycles spent in REQ.
      data_req <= (state_n == S_REQ);
      if (start) begin
        data_wr    <= mem_wr_i;
        data_size  <= sel2size(mem_sel_i);
        data_addr  <= map_addr(mem_addr_i, MAP_KSEG);
        data_wdata <= mem_wdata_i;
      end
      if (rsp_load) rdata_o <= data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_i, mem_wr_i, flush_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        stall_o, rdata_valid_o;
  logic [31:0] rdata_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  dmem_ctrl #(.MAP_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] model_rdata;
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: size from number of enabled bytes, kseg0/1 fold to low 512 MB.
  function automatic req_t model_req(input logic wr, input logic [3:0] sel,
                                     input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    int n;
    n = $countones(sel);
    r.wr    = wr;
    r.size  = (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    r.addr  = ((addr >> 30) == 2) ? (addr % 32'h2000_0000) : addr;
    r.wdata = wdata;
    return r;
  endfunction

  // Monitor: compares every accepted bus request and every completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_o) stall_cnt++;
      if (data_req && data_addr_ok) begin
        if (exp_req.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: addr 0x%08h with no request expected", data_addr);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("bus_wr", {31'b0, data_wr}, {31'b0, r.wr});
          chk("bus_size", {30'b0, data_size}, {30'b0, r.size});
          chk("bus_addr", data_addr, r.addr);
          if (r.wr) chk("bus_wdata", data_wdata, r.wdata);
        end
      end
      if (rdata_valid_o) begin
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: rdata 0x%08h with no completion expected", rdata_o);
        end else begin
          chk("rdata", rdata_o, exp_rsp.pop_front());
        end
      end
    end
  end

  // Called at posedge+#1 with the DUT idle; returns at posedge+#2, idle again.
  task automatic do_txn(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd,
                        input int a_dly, input int d_dly);
    stall_cnt   = 0;
    mem_en_i    = 1'b1; mem_wr_i = wr; mem_sel_i = sel;
    mem_addr_i  = addr; mem_wdata_i = wdata;
    exp_req.push_back(model_req(wr, sel, addr, wdata));
    if (!wr) model_rdata = rd;
    exp_rsp.push_back(model_rdata);
    @(posedge clk); #1;
    repeat (a_dly) begin @(posedge clk); #1; end
    data_addr_ok = 1'b1; data_data_ok = (d_dly == 0); data_rdata = rd;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    if (d_dly > 0) begin
      repeat (d_dly - 1) begin @(posedge clk); #1; end
      data_data_ok = 1'b1;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
    end
    // DONE cycle: mem_en_i still high, must not launch a second access.
    @(posedge clk); #1;
    mem_en_i = 1'b0;
    #1;
    chk("no_restart_req", {31'b0, data_req}, 32'd0);
    chk("stall_cycles", stall_cnt, 2 + a_dly + d_dly);
    chk("rsp_consumed", exp_rsp.size(), 0);
  endtask

  initial begin
    logic [3:0] sels [7];
    logic [3:0] tops [4];
    sels = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tops = '{4'h8, 4'hA, 4'h0, 4'hC};
    model_rdata = '0;
    rst = 1'b1; mem_en_i = 0; mem_wr_i = 0; mem_sel_i = 0; mem_addr_i = 0;
    mem_wdata_i = 0; flush_i = 0; data_rdata = 0; data_addr_ok = 0; data_data_ok = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_req", {31'b0, data_req}, 0);
    chk("rst_wr", {31'b0, data_wr}, 0);
    chk("rst_size", {30'b0, data_size}, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_valid", {31'b0, rdata_valid_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed accesses.
    do_txn(1'b0, 4'b1111, 32'h8000_0010, 32'h0, 32'h1234_5678, 1, 3);
    do_txn(1'b1, 4'b0100, 32'hA000_0002, 32'h1212_1212, 32'hFFFF_0000, 0, 1);
    chk("store_keeps_rdata", rdata_o, 32'h1234_5678);
    do_txn(1'b0, 4'b1100, 32'h0040_0002, 32'h0, 32'hCAFE_0000, 0, 0);

    // Address exception: no request, no stall.
    mem_en_i = 1'b1; mem_sel_i = 4'b0000; mem_addr_i = 32'h8000_0001;
    repeat (3) begin
      #1;
      chk("sel0_stall", {31'b0, stall_o}, 0);
      @(posedge clk); #1;
      chk("sel0_req", {31'b0, data_req}, 0);
    end
    mem_en_i = 1'b0;

    // Flush in IDLE with a pending access: nothing issued.
    mem_en_i = 1'b1; mem_sel_i = 4'b1111; flush_i = 1'b1; #1;
    chk("flush_idle_stall", {31'b0, stall_o}, 0);
    @(posedge clk); #1;
    chk("flush_idle_req", {31'b0, data_req}, 0);
    flush_i = 1'b0; mem_en_i = 1'b0;

    // Flush in REQ before acceptance: request withdrawn.
    mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_0100;
    exp_req.push_back(model_req(1'b0, 4'b1111, 32'h0000_0100, 32'h0));
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; mem_en_i = 1'b0; #1;
    chk("withdraw_req", {31'b0, data_req}, 0);
    chk("withdraw_stall", {31'b0, stall_o}, 0);
    void'(exp_req.pop_back());

    // Flush in WAIT: drain and discard the late response.
    mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h8000_0200;
    exp_req.push_back(model_req(1'b0, 4'b1111, 32'h8000_0200, 32'h0));
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush_i = 1'b1; #1;
    chk("wait_flush_stall", {31'b0, stall_o}, 1);
    @(posedge clk); #1;
    flush_i = 1'b0; mem_en_i = 1'b0; #1;
    chk("drain_stall", {31'b0, stall_o}, 1);
    chk("drain_req", {31'b0, data_req}, 0);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_data_ok = 1'b0; #1;
    chk("drain_done_stall", {31'b0, stall_o}, 0);
    chk("drain_rdata", rdata_o, model_rdata);
    @(posedge clk); #1;
    do_txn(1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 2, 2);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [3:0]  sel;
      logic [31:0] addr;
      wr   = 1'($urandom_range(0, 1));
      sel  = sels[$urandom_range(0, 6)];
      addr = {tops[$urandom_range(0, 3)], 28'($urandom)};
      do_txn(wr, sel, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting for data: everything clears, late data_ok ignored.
    mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_0400;
    exp_req.push_back(model_req(1'b0, 4'b1111, 32'h0000_0400, 32'h0));
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; rst = 1'b1; mem_en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("rst_wait_req", {31'b0, data_req}, 0);
    chk("rst_wait_stall", {31'b0, stall_o}, 0);
    chk("rst_wait_rdata", rdata_o, 0);
    chk("rst_wait_addr", data_addr, 0);
    model_rdata = '0;
    data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    data_data_ok = 1'b0; #1;
    chk("late_ok_rdata", rdata_o, 0);
    chk("late_ok_stall", {31'b0, stall_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("req_queue_empty", exp_req.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
